i2s_clkgen_master: RTL
======================

// Module: i2s_clkgen_master
// PURPOSE
//  Bus-master end of the audio I2S link: generates BCLK and LRCLK from the i2s_clk domain for the codec
//  and for the FPGA-side shift-in/shift-out serialisers, which are BCLK/LRCLK responders.
//  Also emits single-cycle edge and frame strobes so the serialisers run synchronously without resampling BCLK.
//  Start and stop happen only on frame boundaries, so no runt BCLK or LRCLK periods reach the codec.
// PARAMETERS
//  SLOT_BITS  32  BCLK periods per channel slot; frame = 2*SLOT_BITS periods; legal range 2..64
//  DIV_W      8   width of bclk_div
// PORTS
//  clk          in   1          i2s_clk; single clock domain
//  reset        in   1          asynchronous, active-high; clears all state
//  enable       in   1          request generation; sampled every clk
//  bclk_div     in   DIV_W      BCLK half-period in clk cycles, minus 1; sampled only at frame starts
//  bclk         out  1          bit clock to codec/serialisers
//  lrclk        out  1          0 = left slot, 1 = right slot
//  bclk_rise    out  1          1-clk strobe in the cycle bclk becomes 1
//  bclk_fall    out  1          1-clk strobe in the cycle bclk becomes 0
//  frame_start  out  1          1-clk strobe at the first bit of a frame (left slot, bit 0)
//  busy         out  1          1 while in RUN or STOPPING
//  frame_count  out  32         completed frames (only with I2S_CLKGEN_FRAME_CNT_EN)
// BEHAVIOUR
//  - Reset values: bclk = 0, lrclk = 0, all strobes = 0, busy = 0, frame_count = 0, state = IDLE.
//  - All outputs are registered. No combinational path from any input to any output.
//  - FSM states: IDLE, RUN, STOPPING.
//    - IDLE -> RUN when enable = 1. In the cycle after enable is sampled:
//      busy = 1, frame_start = 1, bclk = 0, lrclk = 0, bit_cnt = 0, div_cnt = 0, div_q <= bclk_div.
//    - RUN -> STOPPING when enable = 0.
//    - STOPPING -> RUN when enable = 1, with no disturbance to bclk, lrclk or bit_cnt.
//    - STOPPING -> IDLE at the falling edge that would wrap bit_cnt.
//      In that cycle: bclk = 0, lrclk = 0, busy = 0, no frame_start.
//  - Divider:
//    - div_cnt counts 0..div_q. When it reaches div_q, it resets to 0 and bclk toggles.
//    - One BCLK period = 2*(div_q+1) clk cycles. div_q = 0 gives bclk = clk/2.
//  - bclk 0 -> 1: bclk_rise = 1 in the same cycle.
//  - bclk 1 -> 0: bclk_fall = 1 in the same cycle, and bit_cnt increments.
//    - bit_cnt wraps from 2*SLOT_BITS-1 to 0. On wrap: frame_start = 1 and div_q <= bclk_div.
//    - A bclk_div change mid-frame takes effect only at the next frame.
//  - lrclk = (bit_cnt >= SLOT_BITS). It updates in the same cycle as bit_cnt, i.e. on a bclk falling edge.
//  - bclk_rise and bclk_fall are never high in the same cycle. Neither strobe is high in IDLE.
//  - An async reset mid-frame forces the reset values immediately. No partial frame resumes.
//  - bit_cnt width: $clog2(2*SLOT_BITS). div_cnt width: DIV_W.
// CONFIGURATION
//  - Macro: I2S_CLKGEN_FRAME_CNT_EN.
//  - Defined:
//    - frame_count increments by 1 on every bit_cnt wrap, whether in RUN or STOPPING.
//    - It wraps modulo 2^32, holds its value in IDLE, and is cleared only by reset.
//  - Undefined: the frame_count port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package i2s_pkg:
//    - typedef i2s_clkgen_state_t {IDLE, RUN, STOPPING}
//    - localparam I2S_DEFAULT_SLOT_BITS = 32
//    - function i2s_bitcnt_w(slot_bits) = $clog2(2*slot_bits)
//  - One sub-module, i2s_clkgen_div: a DIV_W-bit reload counter that outputs a toggle strobe.
//    The FSM, bit counter and strobes stay in the top module.
// TESTING  (sim uses SLOT_BITS = 4, DIV_W = 8)
//  - Reset release, enable = 0, 100 clk: bclk = lrclk = busy = 0, no strobes, frame_count = 0.
//  - bclk_div = 0, enable = 1:
//    - frame_start 1 clk later, bclk period = 2 clk.
//    - lrclk rises after the 4th bclk_fall and falls after the 8th.
//    - frame_start repeats every 16 clk.
//  - bclk_div = 2, changed to 5 at bit_cnt = 3:
//    - Current frame keeps a 6-clk BCLK period.
//    - From the next frame_start the period is 12 clk.
//  - enable dropped at bit_cnt = 2:
//    - bclk continues to the 8th falling edge, then busy = 0 and bclk = lrclk = 0.
//    - Exactly 1 frame counted.
//  - enable dropped then re-raised at bit_cnt = 5 (STOPPING): no gap or phase change in bclk/lrclk.
//    frame_count keeps incrementing on each wrap.
//  - reset asserted while bclk = 1 and lrclk = 1: all outputs read 0 in that same cycle.
//    After release, enable = 1 restarts with frame_start and frame_count = 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: clock-generator FSM states, default slot width and
// the bit-counter width helper.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } i2s_clkgen_state_t;

    localparam int I2S_DEFAULT_SLOT_BITS = 32;

    function automatic int i2s_bitcnt_w(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

endpackage

// File: rtl/i2s_clkgen_div.sv
// BCLK half-period divider: counts 0..limit_i while enabled, pulses tick_o on
// the terminal count and reloads to 0. Held at 0 while disabled.
module i2s_clkgen_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [DIV_W-1:0] limit_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2s_clkgen_master.sv
// I2S bus-master clock generator: BCLK/LRCLK plus edge and frame strobes,
// starting and stopping only on frame boundaries.
// Optional completed-frame counter enabled by I2S_CLKGEN_FRAME_CNT_EN.
module i2s_clkgen_master
    import i2s_pkg::*;
#(
    parameter int SLOT_BITS = I2S_DEFAULT_SLOT_BITS,
    parameter int DIV_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] bclk_div,
    output logic             bclk,
    output logic             lrclk,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             frame_start,
    output logic             busy
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    ,
    output logic [31:0]      frame_count
`endif
);

    localparam int             BCW      = i2s_bitcnt_w(SLOT_BITS);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(2 * SLOT_BITS - 1);
    localparam logic [BCW-1:0] HALF_BIT = BCW'(SLOT_BITS);

    i2s_clkgen_state_t state_q, state_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              fs_q, fs_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;
    logic              wrap;
    logic              div_en;
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    logic [31:0]       fcnt_q, fcnt_d;
`endif

    assign div_en = (state_q != IDLE);

    i2s_clkgen_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .en_i    (div_en),
        .limit_i (div_q),
        .tick_o  (tick)
    );

    // The falling edge that ends the last bit of the frame.
    assign wrap = tick && bclk_q && (bit_q == LAST_BIT);

    always_comb begin
        state_d = state_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        fs_d    = 1'b0;
        bit_d   = bit_q;
        div_d   = div_q;
`ifdef I2S_CLKGEN_FRAME_CNT_EN
        fcnt_d  = fcnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    fs_d    = 1'b1;
                    bclk_d  = 1'b0;
                    lrclk_d = 1'b0;
                    bit_d   = '0;
                    div_d   = bclk_div;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (enable) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (div_en && tick) begin
            bclk_d = ~bclk_q;
            rise_d = ~bclk_q;
            // The final falling edge of a stop still strobes bclk_fall so the
            // serialisers see the end of the last bit.
            fall_d = bclk_q;
            if (bclk_q) begin
                bit_d   = wrap ? '0 : bit_q + BCW'(1);
                lrclk_d = (bit_d >= HALF_BIT);
            end
            if (wrap) begin
`ifdef I2S_CLKGEN_FRAME_CNT_EN
                fcnt_d = fcnt_q + 32'd1;
`endif
                if (state_d != IDLE) begin
                    fs_d  = 1'b1;
                    div_d = bclk_div;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fs_q    <= 1'b0;
            bit_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fs_q    <= fs_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
        end
    end

`ifdef I2S_CLKGEN_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_count = fcnt_q;
`endif

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign bclk_rise   = rise_q;
    assign bclk_fall   = fall_q;
    assign frame_start = fs_q;
    assign busy        = (state_q != IDLE);

endmodule
